// File: rtl/uart_regfile.sv
// UART control/status register bank behind the APB bridge request interface.
// Independent write and read FSMs; configuration, TX push, RX pop, sticky errors, irq.
module uart_regfile #(
  parameter logic [15:0] RESET_BAUD = 16'd27
) (
  input  logic        pclk,
  input  logic        prst,
  input  logic        wr_en,
  input  logic [11:0] waddr,
  input  logic [31:0] wdata,
  input  logic        rd_en,
  input  logic [11:0] raddr,
  output logic [31:0] rdata,
  output logic        rack,
  output logic        wack,
  output logic        raddrerr,
  output logic        waddrerr,
  output logic        tx_en,
  output logic        rx_en,
  output logic        stop2,
  output logic [1:0]  parity_mode,
  output logic [15:0] baud_div,
  output logic        tx_push,
  output logic [7:0]  tx_pdata,
  input  logic        tx_full,
  input  logic        tx_empty,
  output logic        rx_pop,
  input  logic [7:0]  rx_pdata,
  input  logic        rx_empty,
  input  logic        rx_full,
  input  logic        rx_overrun_evt,
  input  logic        parity_err_evt,
  output logic        irq
);

  localparam logic [11:0] ADDR_CTRL    = 12'h000;
  localparam logic [11:0] ADDR_BAUD    = 12'h004;
  localparam logic [11:0] ADDR_STATUS  = 12'h008;
  localparam logic [11:0] ADDR_INT_EN  = 12'h00C;
  localparam logic [11:0] ADDR_TX_DATA = 12'h010;
  localparam logic [11:0] ADDR_RX_DATA = 12'h014;
  localparam logic [11:0] ADDR_INT_CLR = 12'h018;

  typedef enum logic [1:0] {W_IDLE, W_ACK, W_DONE} wstate_t;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_RESP, R_DONE} rstate_t;

  wstate_t     wstate;
  rstate_t     rstate;
  logic [4:0]  ctrl;
  logic [2:0]  int_en;
  logic        overrun;
  logic        perr;
  logic        wr_err;
  logic        wr_commit;
  logic        clr_overrun;
  logic        clr_perr;
  logic        rd_err;
  logic        rd_pop;
  logic [31:0] rd_data;
  logic        unused_wdata;

  assign unused_wdata = ^wdata[31:16];

  assign tx_en       = ctrl[0];
  assign rx_en       = ctrl[1];
  assign parity_mode = ctrl[3:2];
  assign stop2       = ctrl[4];

  always_comb begin
    wr_err = 1'b0;
    if (waddr[1:0] != 2'b00) begin
      wr_err = 1'b1;
    end else begin
      case (waddr)
        ADDR_CTRL, ADDR_BAUD, ADDR_INT_EN, ADDR_INT_CLR: wr_err = 1'b0;
        ADDR_TX_DATA: wr_err = tx_full;
        default: wr_err = 1'b1;
      endcase
    end
  end

  // Only the first cycle of a request may commit; a held wr_en never re-commits.
  assign wr_commit   = (wstate == W_IDLE) && wr_en && !wr_err;
  assign clr_overrun = wr_commit && (waddr == ADDR_INT_CLR) && wdata[4];
  assign clr_perr    = wr_commit && (waddr == ADDR_INT_CLR) && wdata[5];

  always_ff @(posedge pclk) begin
    if (prst) begin
      wstate   <= W_IDLE;
      wack     <= 1'b0;
      waddrerr <= 1'b0;
      tx_push  <= 1'b0;
      tx_pdata <= 8'd0;
    end else begin
      wack     <= 1'b0;
      waddrerr <= 1'b0;
      tx_push  <= 1'b0;
      case (wstate)
        W_IDLE: if (wr_en) begin
          wstate   <= W_ACK;
          wack     <= 1'b1;
          waddrerr <= wr_err;
          if (!wr_err && waddr == ADDR_TX_DATA) begin
            tx_push  <= 1'b1;
            tx_pdata <= wdata[7:0];
          end
        end
        W_ACK:   wstate <= W_DONE;
        W_DONE:  if (!wr_en) wstate <= W_IDLE;
        default: wstate <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge pclk) begin
    if (prst) begin
      ctrl     <= 5'd0;
      baud_div <= RESET_BAUD;
      int_en   <= 3'd0;
    end else if (wr_commit) begin
      case (waddr)
        ADDR_CTRL:   ctrl     <= wdata[4:0];
        ADDR_BAUD:   baud_div <= wdata[15:0];
        ADDR_INT_EN: int_en   <= wdata[2:0];
        default: ;
      endcase
    end
  end

  // A core event in the same cycle as the W1C clear keeps the bit set.
  always_ff @(posedge pclk) begin
    if (prst) begin
      overrun <= 1'b0;
      perr    <= 1'b0;
      irq     <= 1'b0;
    end else begin
      overrun <= rx_overrun_evt | (overrun & ~clr_overrun);
      perr    <= parity_err_evt | (perr & ~clr_perr);
      irq     <= (int_en[0] & ~rx_empty) | (int_en[1] & tx_empty) |
                 (int_en[2] & (overrun | perr));
    end
  end

  always_comb begin
    rd_data = 32'd0;
    rd_err  = 1'b0;
    rd_pop  = 1'b0;
    if (raddr[1:0] != 2'b00) begin
      rd_err = 1'b1;
    end else begin
      case (raddr)
        ADDR_CTRL:    rd_data = {27'd0, ctrl};
        ADDR_BAUD:    rd_data = {16'd0, baud_div};
        ADDR_STATUS:  rd_data = {26'd0, perr, overrun, rx_full, rx_empty, tx_empty, tx_full};
        ADDR_INT_EN:  rd_data = {29'd0, int_en};
        ADDR_RX_DATA: if (!rx_empty) begin
          rd_data = {24'd0, rx_pdata};
          rd_pop  = 1'b1;
        end
        default:      rd_err = 1'b1;
      endcase
    end
  end

  always_ff @(posedge pclk) begin
    if (prst) begin
      rstate   <= R_IDLE;
      rack     <= 1'b0;
      rdata    <= 32'd0;
      raddrerr <= 1'b0;
      rx_pop   <= 1'b0;
    end else begin
      rack     <= 1'b0;
      rdata    <= 32'd0;
      raddrerr <= 1'b0;
      rx_pop   <= 1'b0;
      case (rstate)
        R_IDLE: if (rd_en) rstate <= R_ADDR;
        R_ADDR: begin
          rstate   <= R_RESP;
          rack     <= 1'b1;
          rdata    <= rd_data;
          raddrerr <= rd_err;
          rx_pop   <= rd_pop;
        end
        R_RESP:  rstate <= R_DONE;
        R_DONE:  if (!rd_en) rstate <= R_IDLE;
        default: rstate <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_regfile.sv
// Self-checking bench for uart_regfile: directed plan steps plus randomized
// accesses checked against a register-level model of the bank.
module tb_uart_regfile;

  logic        pclk = 1'b0;
  logic        prst;
  logic        wr_en;
  logic [11:0] waddr;
  logic [31:0] wdata;
  logic        rd_en;
  logic [11:0] raddr;
  logic [31:0] rdata;
  logic        rack, wack, raddrerr, waddrerr;
  logic        tx_en, rx_en, stop2;
  logic [1:0]  parity_mode;
  logic [15:0] baud_div;
  logic        tx_push;
  logic [7:0]  tx_pdata;
  logic        tx_full, tx_empty;
  logic        rx_pop;
  logic [7:0]  rx_pdata;
  logic        rx_empty, rx_full;
  logic        rx_overrun_evt, parity_err_evt;
  logic        irq;

  int total = 0;
  int bad = 0;
  int pops = 0;
  int pushes = 0;

  logic [4:0]  mCtrl;
  logic [15:0] mBaud;
  logic [2:0]  mInten;
  logic        mOv, mPe;

  uart_regfile #(.RESET_BAUD(16'd27)) dut (
    .pclk(pclk), .prst(prst),
    .wr_en(wr_en), .waddr(waddr), .wdata(wdata),
    .rd_en(rd_en), .raddr(raddr), .rdata(rdata),
    .rack(rack), .wack(wack), .raddrerr(raddrerr), .waddrerr(waddrerr),
    .tx_en(tx_en), .rx_en(rx_en), .stop2(stop2), .parity_mode(parity_mode),
    .baud_div(baud_div), .tx_push(tx_push), .tx_pdata(tx_pdata),
    .tx_full(tx_full), .tx_empty(tx_empty), .rx_pop(rx_pop), .rx_pdata(rx_pdata),
    .rx_empty(rx_empty), .rx_full(rx_full),
    .rx_overrun_evt(rx_overrun_evt), .parity_err_evt(parity_err_evt), .irq(irq)
  );

  always #5 pclk = ~pclk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    mCtrl = 5'd0; mBaud = 16'd27; mInten = 3'd0; mOv = 1'b0; mPe = 1'b0;
  endtask

  // One clock; irq is predicted from the state held during the cycle that ends.
  task automatic tick();
    logic expIrq;
    logic wasReset;
    wasReset = prst;
    expIrq = prst ? 1'b0 : ((mInten[0] & ~rx_empty) | (mInten[1] & tx_empty) |
                            (mInten[2] & (mOv | mPe)));
    @(posedge pclk);
    #1;
    if (wasReset) modelReset();
    pops += int'(rx_pop);
    pushes += int'(tx_push);
    checkOutput("irq", {31'd0, irq}, {31'd0, expIrq});
  endtask

  function automatic void expRead(input logic [11:0] a, output logic [31:0] d,
                                  output logic e, output logic p);
    d = 32'd0; e = 1'b0; p = 1'b0;
    if (a[1:0] != 2'b00) e = 1'b1;
    else if (a == 12'h000) d = 32'(mCtrl);
    else if (a == 12'h004) d = 32'(mBaud);
    else if (a == 12'h008) d = 32'({mPe, mOv, rx_full, rx_empty, tx_empty, tx_full});
    else if (a == 12'h00C) d = 32'(mInten);
    else if (a == 12'h014) begin
      if (!rx_empty) begin d = 32'(rx_pdata); p = 1'b1; end
    end else e = 1'b1;
  endfunction

  task automatic doRead(input logic [11:0] a, input int hold);
    logic [31:0] ed;
    logic ee, ep;
    int p0;
    rd_en = 1'b1; raddr = 12'hABC;
    tick();
    checkOutput("rack_r1", {31'd0, rack}, 32'd0);
    raddr = a;
    expRead(a, ed, ee, ep);
    p0 = pops;
    tick();
    checkOutput("rack", {31'd0, rack}, 32'd1);
    checkOutput("rdata", rdata, ed);
    checkOutput("raddrerr", {31'd0, raddrerr}, {31'd0, ee});
    checkOutput("rx_pop", {31'd0, rx_pop}, {31'd0, ep});
    for (int i = 0; i < hold; i++) begin
      tick();
      checkOutput("rack_hold", {31'd0, rack}, 32'd0);
      checkOutput("rdata_idle", rdata, 32'd0);
    end
    rd_en = 1'b0;
    tick();
    tick();
    checkOutput("pop_count", 32'(pops - p0), {31'd0, ep});
  endtask

  task automatic applyStimulus(input logic [11:0] a, input logic [31:0] d,
                               input logic ov, input logic pe);
    logic err, push;
    int p0;
    err = (a[1:0] != 2'b00) || !(a inside {12'h000, 12'h004, 12'h00C, 12'h010, 12'h018}) ||
          (a == 12'h010 && tx_full);
    push = !err && (a == 12'h010);
    wr_en = 1'b1; waddr = a; wdata = d;
    rx_overrun_evt = ov; parity_err_evt = pe;
    p0 = pushes;
    tick();
    rx_overrun_evt = 1'b0; parity_err_evt = 1'b0;
    if (!err) begin
      if (a == 12'h000) mCtrl = d[4:0];
      if (a == 12'h004) mBaud = d[15:0];
      if (a == 12'h00C) mInten = d[2:0];
      if (a == 12'h018 && d[4]) mOv = 1'b0;
      if (a == 12'h018 && d[5]) mPe = 1'b0;
    end
    if (ov) mOv = 1'b1;
    if (pe) mPe = 1'b1;
    checkOutput("wack", {31'd0, wack}, 32'd1);
    checkOutput("waddrerr", {31'd0, waddrerr}, {31'd0, err});
    checkOutput("tx_push", {31'd0, tx_push}, {31'd0, push});
    if (push) checkOutput("tx_pdata", {24'd0, tx_pdata}, {24'd0, d[7:0]});
    checkOutput("ctrl_out", {27'd0, stop2, parity_mode, rx_en, tx_en}, {27'd0, mCtrl});
    checkOutput("baud_div", {16'd0, baud_div}, {16'd0, mBaud});
    tick();
    checkOutput("wack_w2", {31'd0, wack}, 32'd0);
    checkOutput("tx_push_w2", {31'd0, tx_push}, 32'd0);
    wr_en = 1'b0;
    tick();
    checkOutput("push_count", 32'(pushes - p0), {31'd0, push});
  endtask

  task automatic pulseEvt(input logic ov, input logic pe);
    rx_overrun_evt = ov; parity_err_evt = pe;
    tick();
    rx_overrun_evt = 1'b0; parity_err_evt = 1'b0;
    if (ov) mOv = 1'b1;
    if (pe) mPe = 1'b1;
  endtask

  logic [11:0] addrTab [12];

  initial begin
    int p0, q0;
    addrTab = '{12'h000, 12'h004, 12'h008, 12'h00C, 12'h010, 12'h014,
                12'h018, 12'h002, 12'h01C, 12'h100, 12'h7FD, 12'h00E};
    prst = 1'b1; wr_en = 1'b0; waddr = 12'd0; wdata = 32'd0;
    rd_en = 1'b0; raddr = 12'd0;
    tx_full = 1'b0; tx_empty = 1'b1; rx_empty = 1'b1; rx_full = 1'b0; rx_pdata = 8'd0;
    rx_overrun_evt = 1'b0; parity_err_evt = 1'b0;
    modelReset();
    tick(); tick(); tick();
    prst = 1'b0;
    checkOutput("rst_wack", {31'd0, wack}, 32'd0);
    checkOutput("rst_rack", {31'd0, rack}, 32'd0);
    checkOutput("rst_rdata", rdata, 32'd0);
    checkOutput("rst_errs", {30'd0, waddrerr, raddrerr}, 32'd0);
    checkOutput("rst_pulses", {30'd0, tx_push, rx_pop}, 32'd0);
    checkOutput("rst_ctrl", {27'd0, stop2, parity_mode, rx_en, tx_en}, 32'd0);
    checkOutput("rst_baud", {16'd0, baud_div}, 32'd27);

    doRead(12'h004, 0);
    doRead(12'h000, 0);
    applyStimulus(12'h000, 32'h1F, 1'b0, 1'b0);
    doRead(12'h000, 0);
    applyStimulus(12'h010, 32'h1A5, 1'b0, 1'b0);
    tx_full = 1'b1;
    applyStimulus(12'h010, 32'h1A5, 1'b0, 1'b0);
    tx_full = 1'b0;
    rx_empty = 1'b0; rx_pdata = 8'h3C;
    doRead(12'h014, 3);
    rx_empty = 1'b1;
    doRead(12'h014, 0);
    applyStimulus(12'h002, 32'h5, 1'b0, 1'b0);
    applyStimulus(12'h008, 32'h3F, 1'b0, 1'b0);
    doRead(12'h008, 0);
    doRead(12'h010, 0);
    doRead(12'h100, 0);

    applyStimulus(12'h00C, 32'h4, 1'b0, 1'b0);
    pulseEvt(1'b1, 1'b0);
    tick();
    checkOutput("irq_ovr", {31'd0, irq}, 32'd1);
    doRead(12'h008, 0);
    applyStimulus(12'h018, 32'h10, 1'b0, 1'b1);
    checkOutput("irq_stay", {31'd0, irq}, 32'd1);
    doRead(12'h008, 1);

    // Reset in the middle of a read, then in the middle of a write.
    q0 = pops;
    rx_empty = 1'b0;
    rd_en = 1'b1; raddr = 12'h014;
    tick();
    prst = 1'b1;
    tick();
    prst = 1'b0; rd_en = 1'b0;
    checkOutput("abort_rack", {31'd0, rack}, 32'd0);
    tick();
    checkOutput("abort_rack2", {31'd0, rack}, 32'd0);
    checkOutput("abort_pop", 32'(pops - q0), 32'd0);
    p0 = pushes;
    wr_en = 1'b1; waddr = 12'h010; wdata = 32'h77; prst = 1'b1;
    tick();
    prst = 1'b0; wr_en = 1'b0;
    checkOutput("abort_wack", {31'd0, wack}, 32'd0);
    tick();
    checkOutput("abort_push", 32'(pushes - p0), 32'd0);
    checkOutput("abort_baud", {16'd0, baud_div}, 32'd27);
    rx_empty = 1'b1;

    for (int i = 0; i < 40; i++) begin
      logic [11:0] a;
      tx_full  = 1'($urandom_range(0, 1));
      tx_empty = 1'($urandom_range(0, 1));
      rx_empty = 1'($urandom_range(0, 1));
      rx_full  = 1'($urandom_range(0, 1));
      rx_pdata = 8'($urandom);
      a = addrTab[$urandom_range(0, 11)];
      if ($urandom_range(0, 5) == 0) pulseEvt(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1)
        applyStimulus(a, $urandom, 1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 7) == 0));
      else
        doRead(a, $urandom_range(0, 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
